nasti_lite_reader: RTL

- Read-side companion of the NASTI-to-lite write bridge: accepts NASTI read bursts on AR and splits every beat into single lite reads of LITE_DATA_WIDTH.
- Reassembles the lite R responses into full-width NASTI R beats.
- Sits between a NASTI master/crossbar port and a NASTI-lite peripheral bus.
- One NASTI burst is in flight at a time; up to BUF_DEPTH lite reads are outstanding.

---
 rtl/nasti_lite_reader_if.sv | 68 ++++++
 rtl/nasti_lite_reader.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/nasti_lite_reader_if.sv
// Signal bundle for nasti_lite_reader: NASTI AR/R channels on one side, NASTI-lite AR/R on the other.
`timescale 1ns/1ps
interface nasti_lite_reader_if #(
  parameter int ID_WIDTH         = 1,
  parameter int ADDR_WIDTH       = 8,
  parameter int NASTI_DATA_WIDTH = 64,
  parameter int LITE_DATA_WIDTH  = 32,
  parameter int USER_WIDTH       = 1
) ();
  logic [ID_WIDTH-1:0]         nasti_ar_id;
  logic [ADDR_WIDTH-1:0]       nasti_ar_addr;
  logic [7:0]                  nasti_ar_len;
  logic [2:0]                  nasti_ar_size;
  logic [1:0]                  nasti_ar_burst;
  logic                        nasti_ar_lock;
  logic [3:0]                  nasti_ar_cache;
  logic [2:0]                  nasti_ar_prot;
  logic [3:0]                  nasti_ar_qos;
  logic [3:0]                  nasti_ar_region;
  logic [USER_WIDTH-1:0]       nasti_ar_user;
  logic                        nasti_ar_valid;
  logic                        nasti_ar_ready;

  logic [ID_WIDTH-1:0]         nasti_r_id;
  logic [NASTI_DATA_WIDTH-1:0] nasti_r_data;
  logic [1:0]                  nasti_r_resp;
  logic                        nasti_r_last;
  logic [USER_WIDTH-1:0]       nasti_r_user;
  logic                        nasti_r_valid;
  logic                        nasti_r_ready;

  logic [ID_WIDTH-1:0]         lite_ar_id;
  logic [ADDR_WIDTH-1:0]       lite_ar_addr;
  logic [2:0]                  lite_ar_prot;
  logic [3:0]                  lite_ar_qos;
  logic [3:0]                  lite_ar_region;
  logic [USER_WIDTH-1:0]       lite_ar_user;
  logic                        lite_ar_valid;
  logic                        lite_ar_ready;

  logic [ID_WIDTH-1:0]         lite_r_id;
  logic [LITE_DATA_WIDTH-1:0]  lite_r_data;
  logic [1:0]                  lite_r_resp;
  logic [USER_WIDTH-1:0]       lite_r_user;
  logic                        lite_r_valid;
  logic                        lite_r_ready;

  // Bridge view: slave on the NASTI side, master on the lite side.
  modport slave (
    input  nasti_ar_id, nasti_ar_addr, nasti_ar_len, nasti_ar_size, nasti_ar_burst,
           nasti_ar_lock, nasti_ar_cache, nasti_ar_prot, nasti_ar_qos, nasti_ar_region,
           nasti_ar_user, nasti_ar_valid, nasti_r_ready, lite_ar_ready,
           lite_r_id, lite_r_data, lite_r_resp, lite_r_user, lite_r_valid,
    output nasti_ar_ready, nasti_r_id, nasti_r_data, nasti_r_resp, nasti_r_last,
           nasti_r_user, nasti_r_valid, lite_ar_id, lite_ar_addr, lite_ar_prot,
           lite_ar_qos, lite_ar_region, lite_ar_user, lite_ar_valid, lite_r_ready
  );

  modport master (
    output nasti_ar_id, nasti_ar_addr, nasti_ar_len, nasti_ar_size, nasti_ar_burst,
           nasti_ar_lock, nasti_ar_cache, nasti_ar_prot, nasti_ar_qos, nasti_ar_region,
           nasti_ar_user, nasti_ar_valid, nasti_r_ready, lite_ar_ready,
           lite_r_id, lite_r_data, lite_r_resp, lite_r_user, lite_r_valid,
    input  nasti_ar_ready, nasti_r_id, nasti_r_data, nasti_r_resp, nasti_r_last,
           nasti_r_user, nasti_r_valid, lite_ar_id, lite_ar_addr, lite_ar_prot,
           lite_ar_qos, lite_ar_region, lite_ar_user, lite_ar_valid, lite_r_ready
  );
endinterface

// File: rtl/nasti_lite_reader.sv
// Splits NASTI read bursts into lite reads and reassembles the lite responses into NASTI R beats.
// Optional lite_r_id check against the burst id: define NASTI_LITE_READER_ID_CHECK_EN.
`timescale 1ns/1ps
module nasti_lite_reader #(
  parameter int BUF_DEPTH        = 2,
  parameter int ID_WIDTH         = 1,
  parameter int ADDR_WIDTH       = 8,
  parameter int NASTI_DATA_WIDTH = 64,
  parameter int LITE_DATA_WIDTH  = 32,
  parameter int USER_WIDTH       = 1
) (
  input logic                clk,
  input logic                rstn,
  nasti_lite_reader_if.slave bus
);
  localparam int LANES       = NASTI_DATA_WIDTH / LITE_DATA_WIDTH;
  localparam int LITE_BYTES  = LITE_DATA_WIDTH / 8;
  localparam int NASTI_BYTES = NASTI_DATA_WIDTH / 8;
  localparam int LANE_W      = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int PTR_W       = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W       = $clog2(BUF_DEPTH + 1);

  generate
    if (LITE_DATA_WIDTH != 32 && LITE_DATA_WIDTH != 64) begin : g_bad_lite_width
      $fatal(1, "nasti_lite_reader: LITE_DATA_WIDTH must be 32 or 64");
    end
    if ((NASTI_DATA_WIDTH % LITE_DATA_WIDTH) != 0 || LANES < 1 || BUF_DEPTH < LANES) begin : g_bad_cfg
      $fatal(1, "nasti_lite_reader: inconsistent data widths or BUF_DEPTH");
    end
  endgenerate

  typedef enum logic {IDLE, BUSY} state_e;

  state_e                  state_q, state_d;
  logic [ID_WIDTH-1:0]     id_q, id_d;
  logic [USER_WIDTH-1:0]   user_q, user_d;
  logic [2:0]              prot_q, prot_d;
  logic [3:0]              qos_q, qos_d, region_q, region_d;
  logic [7:0]              len_q, len_d, beat_q, beat_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d, raddr_q, raddr_d, step_q, step_d;
  logic [CNT_W-1:0]        p_q, p_d, cnt_q, cnt_d;
  logic [11:0]             total_q, total_d, issued_q, issued_d, received_q, received_d;
  logic [PTR_W-1:0]        wp_q, wp_d, rp_q, rp_d;

  logic [LITE_DATA_WIDTH-1:0] buf_data_q [BUF_DEPTH];
  logic [LITE_DATA_WIDTH-1:0] buf_data_d [BUF_DEPTH];
  logic [LANE_W-1:0]          buf_lane_q [BUF_DEPTH];
  logic [LANE_W-1:0]          buf_lane_d [BUF_DEPTH];
  logic [1:0]                 buf_resp_q [BUF_DEPTH];
  logic [1:0]                 buf_resp_d [BUF_DEPTH];
  logic                       buf_err_q  [BUF_DEPTH];
  logic                       buf_err_d  [BUF_DEPTH];

  logic [11:0]                 ar_bits, ar_pkts;
  logic                        lite_ar_valid_w, lite_r_ready_w, nasti_r_valid_w;
  logic                        lar_fire, lr_fire, r_fire, id_err;
  logic [LANE_W-1:0]           lane_in;
  logic [NASTI_DATA_WIDTH-1:0] beat_data;
  logic [1:0]                  beat_resp;
  logic                        beat_err;
  int                          idx, rp_sum;
  logic                        unused_ok;

`ifdef NASTI_LITE_READER_ID_CHECK_EN
  assign id_err = (bus.lite_r_id != id_q);
`else
  assign id_err = 1'b0;
`endif

  assign unused_ok = ^{bus.nasti_ar_lock, bus.nasti_ar_cache, bus.nasti_ar_burst,
                       bus.lite_r_user, bus.lite_r_id};

  // Packets per beat: one lite read per lite-width slice of the beat, at least one.
  always_comb begin
    ar_bits = 12'd8 << bus.nasti_ar_size;
    ar_pkts = ar_bits / 12'(LITE_DATA_WIDTH);
    if (ar_pkts == 12'd0) ar_pkts = 12'd1;
    if (ar_pkts > 12'(LANES)) ar_pkts = 12'(LANES);
  end

  assign lite_ar_valid_w = (state_q == BUSY) && (issued_q < total_q) &&
                           ((issued_q - received_q) < 12'(BUF_DEPTH));
  assign lite_r_ready_w  = (state_q == BUSY) && (cnt_q != CNT_W'(BUF_DEPTH));
  assign nasti_r_valid_w = (state_q == BUSY) && (cnt_q >= p_q);
  assign lane_in         = LANE_W'((int'(raddr_q) % NASTI_BYTES) / LITE_BYTES);

  assign bus.nasti_ar_ready = (state_q == IDLE);
  assign bus.lite_ar_valid  = lite_ar_valid_w;
  assign bus.lite_ar_addr   = addr_q;
  assign bus.lite_ar_id     = id_q;
  assign bus.lite_ar_prot   = prot_q;
  assign bus.lite_ar_qos    = qos_q;
  assign bus.lite_ar_region = region_q;
  assign bus.lite_ar_user   = user_q;
  assign bus.lite_r_ready   = lite_r_ready_w;
  assign bus.nasti_r_valid  = nasti_r_valid_w;
  assign bus.nasti_r_data   = beat_data;
  assign bus.nasti_r_resp   = beat_err ? 2'b10 : beat_resp;
  assign bus.nasti_r_last   = (beat_q == len_q);
  assign bus.nasti_r_id     = id_q;
  assign bus.nasti_r_user   = user_q;

  // Beat assembly reads the P oldest buffer entries; lanes without an entry stay zero.
  always_comb begin
    beat_data = '0;
    beat_resp = 2'b00;
    beat_err  = 1'b0;
    idx       = 0;
    for (int k = 0; k < LANES; k++) begin
      idx = int'(rp_q) + k;
      if (idx >= BUF_DEPTH) idx = idx - BUF_DEPTH;
      if (k < int'(p_q)) begin
        beat_data[int'(buf_lane_q[PTR_W'(idx)]) * LITE_DATA_WIDTH +: LITE_DATA_WIDTH] =
          buf_data_q[PTR_W'(idx)];
        if (buf_resp_q[PTR_W'(idx)] > beat_resp) beat_resp = buf_resp_q[PTR_W'(idx)];
        beat_err = beat_err | buf_err_q[PTR_W'(idx)];
      end
    end
  end

  always_comb begin
    state_d = state_q;  id_d = id_q;  user_d = user_q;  prot_d = prot_q;
    qos_d = qos_q;  region_d = region_q;  len_d = len_q;  beat_d = beat_q;
    addr_d = addr_q;  raddr_d = raddr_q;  step_d = step_q;  p_d = p_q;
    cnt_d = cnt_q;  total_d = total_q;  issued_d = issued_q;  received_d = received_q;
    wp_d = wp_q;  rp_d = rp_q;
    buf_data_d = buf_data_q;  buf_lane_d = buf_lane_q;
    buf_resp_d = buf_resp_q;  buf_err_d = buf_err_q;
    lar_fire = 1'b0;  lr_fire = 1'b0;  r_fire = 1'b0;  rp_sum = 0;
    case (state_q)
      IDLE: begin
        if (bus.nasti_ar_valid) begin
          state_d    = BUSY;
          id_d       = bus.nasti_ar_id;
          user_d     = bus.nasti_ar_user;
          prot_d     = bus.nasti_ar_prot;
          qos_d      = bus.nasti_ar_qos;
          region_d   = bus.nasti_ar_region;
          len_d      = bus.nasti_ar_len;
          addr_d     = bus.nasti_ar_addr;
          raddr_d    = bus.nasti_ar_addr;
          p_d        = CNT_W'(ar_pkts);
          step_d     = (ar_pkts == 12'd1) ? (ADDR_WIDTH'(1) << bus.nasti_ar_size)
                                          : ADDR_WIDTH'(LITE_BYTES);
          total_d    = ({4'd0, bus.nasti_ar_len} + 12'd1) * ar_pkts;
          issued_d   = '0;  received_d = '0;  beat_d = '0;
          cnt_d      = '0;  wp_d = '0;  rp_d = '0;
        end
      end
      BUSY: begin
        lar_fire = lite_ar_valid_w && bus.lite_ar_ready;
        lr_fire  = lite_r_ready_w && bus.lite_r_valid;
        r_fire   = nasti_r_valid_w && bus.nasti_r_ready;
        if (lar_fire) begin
          issued_d = issued_q + 12'd1;
          addr_d   = addr_q + step_q;
        end
        if (lr_fire) begin
          buf_data_d[wp_q] = bus.lite_r_data;
          buf_lane_d[wp_q] = lane_in;
          buf_resp_d[wp_q] = bus.lite_r_resp;
          buf_err_d[wp_q]  = id_err;
          wp_d       = (wp_q == PTR_W'(BUF_DEPTH - 1)) ? '0 : wp_q + 1'b1;
          received_d = received_q + 12'd1;
          raddr_d    = raddr_q + step_q;
        end
        // Releasing a beat frees its P entries in the same cycle a new entry may land.
        if (r_fire) begin
          rp_sum = int'(rp_q) + int'(p_q);
          if (rp_sum >= BUF_DEPTH) rp_sum = rp_sum - BUF_DEPTH;
          rp_d   = PTR_W'(rp_sum);
          beat_d = beat_q + 8'd1;
          if (beat_q == len_q) state_d = IDLE;
        end
        cnt_d = cnt_q + (lr_fire ? CNT_W'(1) : CNT_W'(0)) - (r_fire ? p_q : CNT_W'(0));
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;  id_q <= '0;  user_q <= '0;  prot_q <= '0;
      qos_q <= '0;  region_q <= '0;  len_q <= '0;  beat_q <= '0;
      addr_q <= '0;  raddr_q <= '0;  step_q <= '0;  p_q <= '0;
      cnt_q <= '0;  total_q <= '0;  issued_q <= '0;  received_q <= '0;
      wp_q <= '0;  rp_q <= '0;
    end else begin
      state_q <= state_d;  id_q <= id_d;  user_q <= user_d;  prot_q <= prot_d;
      qos_q <= qos_d;  region_q <= region_d;  len_q <= len_d;  beat_q <= beat_d;
      addr_q <= addr_d;  raddr_q <= raddr_d;  step_q <= step_d;  p_q <= p_d;
      cnt_q <= cnt_d;  total_q <= total_d;  issued_q <= issued_d;  received_q <= received_d;
      wp_q <= wp_d;  rp_q <= rp_d;
    end
  end

  always_ff @(posedge clk) begin
    buf_data_q <= buf_data_d;
    buf_lane_q <= buf_lane_d;
    buf_resp_q <= buf_resp_d;
    buf_err_q  <= buf_err_d;
  end
endmodule
